// File: rtl/decode_ctrl_pipe_if.sv
// Decode-to-execute control bus: decode-side inputs, hazard controls and
// the registered E-stage control bundle.
interface decode_ctrl_pipe_if #(
  parameter int D_WIDTH    = 32,
  parameter int ALU_CTRL_W = 4
);
  logic [D_WIDTH-1:0]    instr_d;
  logic                  valid_d;
  logic                  stall_i;
  logic                  flush_i;
  logic [1:0]            result_src_e;
  logic                  mem_write_e;
  logic [ALU_CTRL_W-1:0] alu_control_e;
  logic                  alu_src_e;
  logic [2:0]            imm_src_e;
  logic                  reg_write_e;
  logic                  jump_e;
  logic                  branch_e;
  logic                  jalr_e;
  logic                  valid_e;
  logic                  illegal_e;
  logic                  mul_busy_o;

  modport master (
    output instr_d, valid_d, stall_i, flush_i,
    input  result_src_e, mem_write_e, alu_control_e, alu_src_e, imm_src_e,
           reg_write_e, jump_e, branch_e, jalr_e, valid_e, illegal_e, mul_busy_o
  );

  modport slave (
    input  instr_d, valid_d, stall_i, flush_i,
    output result_src_e, mem_write_e, alu_control_e, alu_src_e, imm_src_e,
           reg_write_e, jump_e, branch_e, jalr_e, valid_e, illegal_e, mul_busy_o
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// RV32I (+ optional MUL) decode-stage control unit with the D/E control
// register, stall/flush handling and a multi-cycle MUL sequencer.
module decode_ctrl_pipe #(
  parameter int D_WIDTH    = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int M_EXT      = 1,
  parameter int MUL_CYCLES = 3
) (
  input logic              clk,
  input logic              rst_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = 5;

  localparam logic [ALU_CTRL_W-1:0] A_ADD   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] A_SUB   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] A_AND   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] A_OR    = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] A_XOR   = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] A_SLT   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] A_SLTU  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] A_SLL   = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] A_SRL   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] A_SRA   = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] A_PASSB = ALU_CTRL_W'(10);
  localparam logic [ALU_CTRL_W-1:0] A_MUL   = ALU_CTRL_W'(11);

  typedef struct packed {
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
    logic [2:0]            imm_src;
    logic                  reg_write;
    logic                  jump;
    logic                  branch;
    logic                  jalr;
    logic                  illegal;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [D_WIDTH-1:0] instr_w;
  logic [31:0]        instr;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               unused_fields;

  ctrl_t              dec;
  logic               dec_is_mul;

  ctrl_t              ctrl_p1;
  logic               vld_p1;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mul_busy;

  assign instr_w       = bus.instr_d;
  assign instr         = instr_w[31:0];
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^instr[24:15] ^ ^instr[11:7];

  // Register-register / immediate ALU op selected by funct3 alone
  function automatic logic [ALU_CTRL_W-1:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // ---- D stage: combinational decode of the instruction in decode ----
  always_comb begin
    logic bad;
    dec        = '0;
    dec_is_mul = 1'b0;
    bad        = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_control = alu_from_f3(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_control = A_SUB;
            else if (funct3 == 3'b101) dec.alu_control = A_SRA;
            else                       bad = 1'b1;
          end
          7'b0000001: begin
            if (M_EXT != 0 && funct3 == 3'b000) begin
              dec.alu_control = A_MUL;
              dec_is_mul      = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        if (funct3 == 3'b001) begin
          dec.alu_control = A_SLL;
          bad             = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000)      dec.alu_control = A_SRL;
          else if (funct7 == 7'b0100000) dec.alu_control = A_SRA;
          else                           bad = 1'b1;
        end else begin
          // funct7 here is immediate data, so ADDI never turns into SUB
          dec.alu_control = alu_from_f3(funct3);
        end
      end
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        bad            = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
        bad           = (funct3 > 3'b010);
      end
      7'b1100011: begin
        dec.branch      = 1'b1;
        dec.alu_control = A_SUB;
        dec.imm_src     = 3'b010;
        bad             = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b0110111: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm_src     = 3'b011;
        dec.alu_control = A_PASSB;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b011;
      end
      7'b1101111: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = 3'b100;
      end
      7'b1100111: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        bad            = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // Illegal instructions carry only the flag so nothing is written back
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec_is_mul  = 1'b0;
    end
  end

  // ---- D/E boundary: control register, hazard priority and MUL sequencer ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_p1  <= '0;
      vld_p1   <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      mul_busy <= 1'b0;
    end else if (bus.flush_i) begin
      ctrl_p1  <= '0;
      vld_p1   <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      mul_busy <= 1'b0;
    end else if (state == BUSY) begin
      // MUL stays in E; the count keeps running even under an external stall
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state    <= IDLE;
        mul_busy <= 1'b0;
      end
    end else if (!bus.stall_i) begin
      if (bus.valid_d) begin
        ctrl_p1 <= dec;
        vld_p1  <= 1'b1;
        if (dec_is_mul && MUL_CYCLES > 1) begin
          state    <= BUSY;
          cnt      <= CNT_W'(MUL_CYCLES - 1);
          mul_busy <= 1'b1;
        end
      end else begin
        ctrl_p1 <= '0;
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.result_src_e  = ctrl_p1.result_src;
  assign bus.mem_write_e   = ctrl_p1.mem_write;
  assign bus.alu_control_e = ctrl_p1.alu_control;
  assign bus.alu_src_e     = ctrl_p1.alu_src;
  assign bus.imm_src_e     = ctrl_p1.imm_src;
  assign bus.reg_write_e   = ctrl_p1.reg_write;
  assign bus.jump_e        = ctrl_p1.jump;
  assign bus.branch_e      = ctrl_p1.branch;
  assign bus.jalr_e        = ctrl_p1.jalr;
  assign bus.illegal_e     = ctrl_p1.illegal;
  assign bus.valid_e       = vld_p1;
  assign bus.mul_busy_o    = mul_busy;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized self-checking bench for decode_ctrl_pipe: one instance with the
// M extension, one without, both compared against a behavioural model.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.D_WIDTH(32), .ALU_CTRL_W(4)) if0 ();
  decode_ctrl_pipe_if #(.D_WIDTH(32), .ALU_CTRL_W(4)) if1 ();

  decode_ctrl_pipe #(.D_WIDTH(32), .ALU_CTRL_W(4), .M_EXT(1), .MUL_CYCLES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  decode_ctrl_pipe #(.D_WIDTH(32), .ALU_CTRL_W(4), .M_EXT(0), .MUL_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  assign if1.instr_d = if0.instr_d;
  assign if1.valid_d = if0.valid_d;
  assign if1.stall_i = if0.stall_i;
  assign if1.flush_i = if0.flush_i;

  typedef struct packed {
    logic [1:0] rs;
    logic       mw;
    logic [3:0] alu;
    logic       as;
    logic [2:0] imm;
    logic       rw;
    logic       j;
    logic       b;
    logic       jr;
    logic       v;
    logic       il;
  } bun_t;

  localparam int MC = 3;

  int   n_tests = 0;
  int   n_fail  = 0;
  bun_t exp_e [2];
  int   rem   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    return tbl[f3];
  endfunction

  // Expected control bundle straight from the instruction-set tables
  function automatic bun_t ref_dec(input logic [31:0] ins, input bit mext);
    bun_t r;
    bit   bad;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    r = '0; bad = 0;
    case (op)
      7'h33: begin
        r.rw = 1;
        if (f7 == 0) r.alu = base_op(f3);
        else if (f7 == 7'h20 && f3 == 0) r.alu = 1;
        else if (f7 == 7'h20 && f3 == 5) r.alu = 9;
        else if (f7 == 7'h01 && f3 == 0 && mext) r.alu = 11;
        else bad = 1;
      end
      7'h13: begin
        r.rw = 1; r.as = 1;
        if (f3 == 1) begin r.alu = 7; bad = (f7 != 0); end
        else if (f3 == 5) begin
          if (f7 == 0) r.alu = 8; else if (f7 == 7'h20) r.alu = 9; else bad = 1;
        end else r.alu = base_op(f3);
      end
      7'h03: begin r.rw = 1; r.as = 1; r.rs = 1; bad = (f3 == 3 || f3 >= 6); end
      7'h23: begin r.mw = 1; r.as = 1; r.imm = 1; bad = (f3 > 2); end
      7'h63: begin r.b = 1; r.alu = 1; r.imm = 2; bad = (f3 == 2 || f3 == 3); end
      7'h37: begin r.rw = 1; r.as = 1; r.imm = 3; r.alu = 10; end
      7'h17: begin r.rw = 1; r.as = 1; r.imm = 3; end
      7'h6F: begin r.rw = 1; r.j = 1; r.rs = 2; r.imm = 4; end
      7'h67: begin r.rw = 1; r.j = 1; r.jr = 1; r.as = 1; r.rs = 2; bad = (f3 != 0); end
      default: bad = 1;
    endcase
    if (bad) begin r = '0; r.il = 1; end
    r.v = 1;
    return r;
  endfunction

  // One clock: advance the model with the current inputs, then compare both DUTs
  task automatic tick();
    logic [17:0] g0, g1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || if0.flush_i) begin
        exp_e[k] = '0; rem[k] = 0;
      end else if (if0.stall_i || rem[k] > 0) begin
        if (rem[k] > 0) rem[k]--;
      end else if (!if0.valid_d) begin
        exp_e[k] = '0;
      end else begin
        exp_e[k] = ref_dec(if0.instr_d, k == 0);
        if (exp_e[k].alu == 4'd11 && !exp_e[k].il && MC > 1) rem[k] = MC - 1;
      end
    end
    #1;
    g0 = {if0.result_src_e, if0.mem_write_e, if0.alu_control_e, if0.alu_src_e, if0.imm_src_e,
          if0.reg_write_e, if0.jump_e, if0.branch_e, if0.jalr_e, if0.valid_e, if0.illegal_e,
          if0.mul_busy_o};
    g1 = {if1.result_src_e, if1.mem_write_e, if1.alu_control_e, if1.alu_src_e, if1.imm_src_e,
          if1.reg_write_e, if1.jump_e, if1.branch_e, if1.jalr_e, if1.valid_e, if1.illegal_e,
          if1.mul_busy_o};
    chk("bundle_mext1", 32'(g0), 32'({exp_e[0], rem[0] > 0}));
    chk("bundle_mext0", 32'(g1), 32'({exp_e[1], rem[1] > 0}));
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    if0.instr_d = ins; if0.valid_d = v; if0.stall_i = st; if0.flush_i = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] f7s [4];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    ins = $urandom;
    if ($urandom_range(0, 15) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 7) != 0) ins[31:25] = f7s[$urandom_range(0, 3)];
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(32'h00A00093, 1, 0, 0);
    exp_e[0] = '0; exp_e[1] = '0; rem[0] = 0; rem[1] = 0;

    // Reset held two cycles, then addi x1,x0,10 loads
    tick(); tick();
    chk("reset_valid", 32'(if0.valid_e), 0);
    chk("reset_rw", 32'(if0.reg_write_e), 0);
    rst_n = 1'b1;
    tick();
    chk("addi_rw", 32'(if0.reg_write_e), 1);
    chk("addi_as", 32'(if0.alu_src_e), 1);
    chk("addi_alu", 32'(if0.alu_control_e), 0);
    chk("addi_vld", 32'(if0.valid_e), 1);

    // sub then lw
    drive(32'h40B50533, 1, 0, 0); tick();
    chk("sub_alu", 32'(if0.alu_control_e), 1);
    chk("sub_rs", 32'(if0.result_src_e), 0);
    drive(32'h0005A503, 1, 0, 0); tick();
    chk("lw_rs", 32'(if0.result_src_e), 1);
    chk("lw_as", 32'(if0.alu_src_e), 1);

    // MUL occupies E for three cycles, busy for two
    drive(32'h02B50533, 1, 0, 0); tick();
    chk("mul_c1_alu", 32'(if0.alu_control_e), 11);
    chk("mul_c1_busy", 32'(if0.mul_busy_o), 1);
    chk("mul_m0_ill", 32'(if1.illegal_e), 1);
    drive(32'h00A00093, 1, 0, 0); tick();
    chk("mul_c2_alu", 32'(if0.alu_control_e), 11);
    chk("mul_c2_busy", 32'(if0.mul_busy_o), 1);
    tick();
    chk("mul_c3_alu", 32'(if0.alu_control_e), 11);
    chk("mul_c3_busy", 32'(if0.mul_busy_o), 0);
    tick();
    chk("mul_next_alu", 32'(if0.alu_control_e), 0);
    chk("mul_next_rw", 32'(if0.reg_write_e), 1);

    // MUL flushed in its second cycle
    drive(32'h02B50533, 1, 0, 0); tick();
    drive(32'h02B50533, 1, 0, 1); tick();
    chk("mulflush_vld", 32'(if0.valid_e), 0);
    chk("mulflush_busy", 32'(if0.mul_busy_o), 0);
    chk("mulflush_alu", 32'(if0.alu_control_e), 0);

    // Stall holds, stall+flush bubbles
    drive(32'h40B50533, 1, 0, 0); tick();
    drive(32'h0005A503, 1, 1, 0); tick();
    chk("stall1_alu", 32'(if0.alu_control_e), 1);
    drive(32'h00A00093, 1, 1, 0); tick();
    chk("stall2_rs", 32'(if0.result_src_e), 0);
    chk("stall2_alu", 32'(if0.alu_control_e), 1);
    drive(32'h00A00093, 1, 1, 1); tick();
    chk("stflush_vld", 32'(if0.valid_e), 0);

    // All-ones instruction is illegal
    drive(32'hFFFFFFFF, 1, 0, 0); tick();
    chk("ill_flag", 32'(if0.illegal_e), 1);
    chk("ill_vld", 32'(if0.valid_e), 1);
    chk("ill_rw", 32'(if0.reg_write_e), 0);
    chk("ill_mw", 32'(if0.mem_write_e), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(rand_instr(), $urandom_range(0, 9) != 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 12) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Parametrised successor to the decode-stage control unit.
- Decodes the RV32I instruction (plus optional M-extension MUL) into control bundles and registers them into the D/E pipeline boundary.
- Handles stall (hold) and flush (bubble) from the hazard unit, and sequences multi-cycle MUL with an internal FSM that back-pressures fetch/decode.
- Sits between the IF/ID register and the execute stage.

Parameters:
- D_WIDTH, 32, instruction width (bits [31:0] decoded; upper bits ignored if wider).
- ALU_CTRL_W, 4, ALUControl width; must be ≥4.
- M_EXT, 1, 1 = decode MUL (funct7=0000001, funct3=000); 0 = treat as illegal.
- MUL_CYCLES, 3, total execute cycles of MUL; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- instr_d  in  D_WIDTH  instruction in decode.
- valid_d  in  1  instr_d holds a real instruction.
- stall_i  in  1  hazard unit: hold E-register.
- flush_i  in  1  hazard unit: load bubble into E-register.
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4.
- mem_write_e  out  1  store.
- alu_control_e  out  ALU_CTRL_W  operation encoding (listed under Behaviour).
- alu_src_e  out  1  1 = immediate operand B.
- imm_src_e  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- reg_write_e  out  1  register writeback.
- jump_e  out  1  JAL/JALR.
- branch_e  out  1  conditional branch.
- jalr_e  out  1  JALR target select.
- valid_e  out  1  E-register holds a real instruction.
- illegal_e  out  1  unsupported opcode/funct captured.
- mul_busy_o  out  1  MUL in progress; fetch/decode must stall.

Behaviour:
- Reset (rst_n=0 at clk edge): every output 0; FSM to IDLE; counter 0. Reset mid-MUL aborts immediately.
- ALU encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB (LUI), 11 MUL.
- Decode is combinational; all _e outputs are registered with 1-cycle latency.
- R-type (0110011): SUB/SRA when funct7[5]=1. I-ALU (0010011): SRAI when funct7[5]=1; funct7[5] never selects SUB.
- Loads/stores/AUIPC/JAL/JALR use ADD. Branches use SUB (funct3 passed through by datapath).
- Illegal: unknown opcode or unsupported funct.
  - Registers illegal_e=1, valid_e=1.
  - All other control 0, so reg_write_e and mem_write_e are suppressed.
- Register update priority, highest first:
  1. flush_i: bubble, all outputs 0.
  2. stall_i or mul_busy_o: hold.
  3. Otherwise load decoded bundle, valid_e=valid_d.
- valid_d=0 loads a bubble.
- FSM states IDLE and BUSY.
  - IDLE→BUSY when a MUL is loaded into E (M_EXT=1, MUL_CYCLES>1). Counter loads MUL_CYCLES-1.
  - BUSY: mul_busy_o=1 (registered), E-register holds the MUL bundle, counter decrements each cycle.
  - BUSY→IDLE when counter reaches 1 and decrements to 0. mul_busy_o drops in that same transition, so the MUL occupies E for exactly MUL_CYCLES cycles.
  - flush_i in BUSY: go to IDLE, counter 0, bubble loaded.
  - stall_i in BUSY does not freeze the counter.
- MUL_CYCLES=1: MUL behaves as a single-cycle op; BUSY is never entered.
- Simultaneous flush_i and stall_i: flush wins.

Test Plan:
- Reset held 2 cycles with instr_d=0x00A00093 → all outputs 0. First edge after release: reg_write_e=1, alu_src_e=1, imm_src_e=000, alu_control_e=0, valid_e=1.
- instr_d=0x40B50533 (sub) then 0x0005A503 (lw) → cycle1 alu_control_e=1, result_src_e=00; cycle2 result_src_e=01, alu_src_e=1, reg_write_e=1.
- MUL 0x02B50533, MUL_CYCLES=3 → alu_control_e=11 for exactly 3 cycles; mul_busy_o high for 2 cycles; next instruction in E on cycle 4.
- MUL then flush_i in its 2nd cycle → next edge: all outputs 0, mul_busy_o=0, FSM IDLE.
- stall_i=1 for 2 cycles with changing instr_d → E outputs unchanged. stall_i+flush_i together → bubble.
- instr_d=0xFFFFFFFF → illegal_e=1, valid_e=1, reg_write_e=0, mem_write_e=0. With M_EXT=0, the MUL encoding also gives illegal_e=1.
